elevator_motion: RTL

Car motion controller for the 2-way, 7-floor elevator. It latches car and hall calls, selects travel direction using collective (keep-direction) scanning, and steps the car floor by floor on a travel timer. It drives the floor, direction, and hall-call inputs that the door controller consumes, and its `moving` output gates that controller's reset. It is the producer end of the door interface and observes `doorState` to sequence each stop.

---
 rtl/elevator_pkg.sv | 32 +++
 rtl/request_latch.sv | 63 ++++++
 rtl/elevator_motion.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared elevator codes, floor bounds and motion states
package elevator_pkg;

    localparam logic [1:0] STOP   = 2'b00;
    localparam logic [1:0] UP     = 2'b10;
    localparam logic [1:0] DOWN   = 2'b01;
    localparam logic [1:0] UPDOWN = 2'b11;

    localparam logic OPEN  = 1'b1;
    localparam logic CLOSE = 1'b0;
    localparam logic ON    = 1'b1;
    localparam logic OFF   = 1'b0;

    localparam int OPEN_B    = 9;
    localparam int CLOSE_B   = 8;
    localparam int FLOOR_MIN = 1;
    localparam int FLOOR_MAX = 7;

    typedef enum logic [2:0] {
        IDLE,
        MOVE,
        ARRIVE,
        SERVE,
        DECIDE
    } motionState_t;

    typedef enum logic {
        WAIT_OPEN,
        WAIT_CLOSE
    } servePhase_t;

endpackage

// File: rtl/request_latch.sv
// rtl/request_latch.sv - car and hall call latches with above/below/here reductions
module request_latch
    import elevator_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:1] carSet,
    input  logic [7:1] upSet,
    input  logic [7:1] downSet,
    input  logic [2:0] floor,
    input  logic       clear,
    input  logic       clearUp,
    output logic [7:1] carLamp,
    output logic [7:1] upLamp,
    output logic [7:1] downLamp,
    output logic       above,
    output logic       below,
    output logic       here
);

    logic [7:1] floorMask;
    logic [7:1] carClr;
    logic [7:1] upClr;
    logic [7:1] downClr;
    logic [7:1] anyCall;

    always_comb begin
        floorMask = '0;
        for (int f = FLOOR_MIN; f <= FLOOR_MAX; f++) begin
            if (3'(f) == floor) floorMask[f] = 1'b1;
        end
    end

    assign carClr  = clear ? floorMask : '0;
    assign upClr   = (clear && clearUp) ? floorMask : '0;
    assign downClr = (clear && !clearUp) ? floorMask : '0;

    // Top floor has no up button and bottom floor no down button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carLamp  <= '0;
            upLamp   <= '0;
            downLamp <= '0;
        end else begin
            carLamp  <= (carLamp | carSet) & ~carClr;
            upLamp   <= (upLamp | (upSet & 7'b0111111)) & ~upClr;
            downLamp <= (downLamp | (downSet & 7'b1111110)) & ~downClr;
        end
    end

    assign anyCall = carLamp | upLamp | downLamp;
    assign here    = |(anyCall & floorMask);

    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int f = FLOOR_MIN; f <= FLOOR_MAX; f++) begin
            if (3'(f) > floor) above = above | anyCall[f];
            if (3'(f) < floor) below = below | anyCall[f];
        end
    end

endmodule

// File: rtl/elevator_motion.sv
// rtl/elevator_motion.sv - collective-scan car motion controller driving the door interface
module elevator_motion
    import elevator_pkg::*;
#(
    parameter int unsigned CLK_PER_FLOOR = 100000000,
    parameter int unsigned DOOR_TIMEOUT  = 1000000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:1] internalButton,
    input  logic [7:1] hallUp,
    input  logic [7:1] hallDown,
    input  logic       doorState,
    output logic [2:0] currentFloor,
    output logic [1:0] currentDirection,
    output logic [1:0] currentFloorButton,
    output logic       moving,
    output logic [7:1] carLamp,
    output logic [7:1] upLamp,
    output logic [7:1] downLamp
);

    localparam logic [31:0] TRAVEL_LOAD = 32'(CLK_PER_FLOOR - 1);
    localparam logic [31:0] SERVE_LAST  = 32'(DOOR_TIMEOUT - 1);

    motionState_t state, stateNext;
    servePhase_t  phase, phaseNext;
    logic [31:0]  travelCnt, travelNext;
    logic [31:0]  serveCnt, serveNext;
    logic [2:0]   floorQ, floorNext;
    logic [1:0]   dirQ, dirNext;
    logic         latchClear, latchClearUp;
    logic         above, below, here;
    logic [7:0]   carExt, upExt, downExt;
    logic         carHere, upHere, matchHall, oppHall;
    logic         ahead, behind;
    logic [1:0]   reverseDir;
    logic         unusedPanel;

    assign unusedPanel = internalButton[OPEN_B] ^ internalButton[CLOSE_B];

    request_latch u_requests (
        .clk      (clk),
        .reset    (reset),
        .carSet   (internalButton[7:1]),
        .upSet    (hallUp),
        .downSet  (hallDown),
        .floor    (floorQ),
        .clear    (latchClear),
        .clearUp  (latchClearUp),
        .carLamp  (carLamp),
        .upLamp   (upLamp),
        .downLamp (downLamp),
        .above    (above),
        .below    (below),
        .here     (here)
    );

    assign carExt     = {carLamp, 1'b0};
    assign upExt      = {upLamp, 1'b0};
    assign downExt    = {downLamp, 1'b0};
    assign carHere    = carExt[floorQ];
    assign upHere     = upExt[floorQ];
    assign matchHall  = (dirQ == UP) ? upExt[floorQ] : downExt[floorQ];
    assign oppHall    = (dirQ == UP) ? downExt[floorQ] : upExt[floorQ];
    assign ahead      = (dirQ == UP) ? above : below;
    assign behind     = (dirQ == UP) ? below : above;
    assign reverseDir = (dirQ == UP) ? DOWN : UP;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= WAIT_OPEN;
            travelCnt <= '0;
            serveCnt  <= '0;
            floorQ    <= 3'(FLOOR_MIN);
            dirQ      <= STOP;
        end else begin
            state     <= stateNext;
            phase     <= phaseNext;
            travelCnt <= travelNext;
            serveCnt  <= serveNext;
            floorQ    <= floorNext;
            dirQ      <= dirNext;
        end
    end

    always_comb begin
        stateNext    = state;
        phaseNext    = phase;
        travelNext   = travelCnt;
        serveNext    = serveCnt;
        floorNext    = floorQ;
        dirNext      = dirQ;
        latchClear   = 1'b0;
        latchClearUp = (dirQ == UP);
        case (state)
            IDLE: begin
                dirNext = STOP;
                if (here) begin
                    dirNext   = (carHere || upHere) ? UP : DOWN;
                    stateNext = SERVE;
                    phaseNext = WAIT_OPEN;
                    serveNext = '0;
                end else if (above) begin
                    dirNext    = UP;
                    stateNext  = MOVE;
                    travelNext = TRAVEL_LOAD;
                end else if (below) begin
                    dirNext    = DOWN;
                    stateNext  = MOVE;
                    travelNext = TRAVEL_LOAD;
                end
            end
            MOVE: begin
                if (travelCnt == '0) begin
                    floorNext = (dirQ == UP) ? floorQ + 3'd1 : floorQ - 3'd1;
                    stateNext = ARRIVE;
                end else begin
                    travelNext = travelCnt - 32'd1;
                end
            end
            ARRIVE: begin
                // Nothing left ahead also covers the top and bottom floors.
                if (carHere || matchHall || !ahead) begin
                    stateNext = SERVE;
                    phaseNext = WAIT_OPEN;
                    serveNext = '0;
                    if (!ahead && oppHall && !carHere && !matchHall) dirNext = reverseDir;
                end else begin
                    stateNext  = MOVE;
                    travelNext = TRAVEL_LOAD;
                end
            end
            SERVE: begin
                serveNext = serveCnt + 32'd1;
                if (serveCnt == SERVE_LAST) begin
                    latchClear = 1'b1;
                    stateNext  = DECIDE;
                end else if (phase == WAIT_OPEN && doorState == OPEN) begin
                    latchClear = 1'b1;
                    phaseNext  = WAIT_CLOSE;
                end else if (phase == WAIT_CLOSE && doorState == CLOSE) begin
                    stateNext = DECIDE;
                end
            end
            DECIDE: begin
                serveNext = '0;
                if ((dirQ == UP && above) || (dirQ == DOWN && below)) begin
                    stateNext  = MOVE;
                    travelNext = TRAVEL_LOAD;
                end else if (behind || here) begin
                    dirNext = reverseDir;
                    if (here) begin
                        stateNext = SERVE;
                        phaseNext = WAIT_OPEN;
                    end else begin
                        stateNext  = MOVE;
                        travelNext = TRAVEL_LOAD;
                    end
                end else begin
                    dirNext   = STOP;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign currentFloor       = floorQ;
    assign currentDirection   = dirQ;
    assign moving             = (state == MOVE) || (state == ARRIVE);
    assign currentFloorButton = {upExt[floorQ], downExt[floorQ]};

    assert property (@(posedge clk) disable iff (reset)
        !(state == MOVE && travelCnt == '0 &&
          ((dirQ == UP && floorQ == 3'(FLOOR_MAX)) || (dirQ == DOWN && floorQ == 3'(FLOOR_MIN)))));

endmodule
